// File: rtl/lcd_id_if.sv
// lcd_id_if: RGB pad view and panel-ID result bus between pad logic, ID reader and clock divider.
interface lcd_id_if;
   logic [23:0] lcd_rgb_in;
   logic        reread;
   logic        lcd_rgb_oe;
   logic [15:0] lcd_id;
   logic        id_valid;
   logic        id_err;
   logic        busy;
   modport slave (input lcd_rgb_in, reread, output lcd_rgb_oe, lcd_id, id_valid, id_err, busy);
   modport master (output lcd_rgb_in, reread, input lcd_rgb_oe, lcd_id, id_valid, id_err, busy);
endinterface

// File: rtl/lcd_id_reader.sv
// lcd_id_reader: releases the RGB bus, samples the M2/M1/M0 straps until stable and holds the decoded panel ID.
// Define LCD_ID_SYNC_EN to pass the strap bits through a 2-flop synchronizer.
module lcd_id_reader #(
   parameter int SETTLE_CYC = 1000,
   parameter int SAMPLE_GAP = 16,
   parameter int STABLE_N   = 4,
   parameter int MAX_TRY    = 64
) (
   input logic    clk,
   input logic    rst_n,
   lcd_id_if.slave bus
);
   typedef enum logic [1:0] {RELEASE, SAMPLE, DONE} state_t;
`ifdef LCD_ID_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif
   // The settle window also covers the synchronizer depth so the first sample sees post-release pads.
   localparam int SETTLE_TOT = SETTLE_CYC + SYNC_LAT;
   localparam int CW = $clog2(SETTLE_TOT);
   localparam int GW = $clog2(SAMPLE_GAP);
   localparam int MW = $clog2(STABLE_N + 1);
   localparam int TW = $clog2(MAX_TRY + 1);
   localparam logic [CW-1:0] CNT_END = CW'(SETTLE_TOT - 1);
   localparam logic [GW-1:0] GAP_END = GW'(SAMPLE_GAP - 1);
   localparam logic [MW-1:0] M_END = MW'(STABLE_N);
   localparam logic [TW-1:0] T_END = TW'(MAX_TRY);
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic [GW-1:0] gap;
   logic [MW-1:0] match;
   logic [TW-1:0] tries;
   logic [2:0] raw, strap, strap_ref;
   logic [15:0] id, dec_id;
   logic err, take, stable, dec_ok;
   assign raw = {bus.lcd_rgb_in[7], bus.lcd_rgb_in[15], bus.lcd_rgb_in[23]};
`ifdef LCD_ID_SYNC_EN
   logic [2:0] sync1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {sync1, strap} <= '0;
      else {sync1, strap} <= {raw, sync1};
`else
   assign strap = raw;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= RELEASE;
      else state <= nxt;
   always_comb begin
      take = state == SAMPLE && gap == GAP_END;
      stable = match == M_END;
      dec_id = strap_ref == 3'b000 ? 16'h4342 :
               strap_ref == 3'b001 ? 16'h7084 :
               strap_ref == 3'b010 ? 16'h7016 :
               strap_ref == 3'b100 ? 16'h4384 :
               strap_ref == 3'b101 ? 16'h1018 : 16'h0000;
      dec_ok = strap_ref inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      nxt = state;
      nxt = (state == RELEASE && cnt == CNT_END) ? SAMPLE :
            (state == SAMPLE && (stable || tries == T_END)) ? DONE :
            (state == DONE && bus.reread) ? RELEASE : state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         gap <= '0;
         match <= '0;
         tries <= '0;
         strap_ref <= '0;
         id <= '0;
         err <= 1'b0;
      end else begin
         cnt <= (state == RELEASE && nxt == RELEASE) ? cnt + CW'(1) : '0;
         gap <= (state == SAMPLE && nxt == SAMPLE && !take) ? gap + GW'(1) : '0;
         if (take) begin
            strap_ref <= strap;
            match <= (tries != '0 && strap == strap_ref) ? match + MW'(1) : MW'(1);
            tries <= tries + TW'(1);
         end
         if (state == SAMPLE && nxt == DONE) begin
            id <= (stable && dec_ok) ? dec_id : 16'h0000;
            err <= !(stable && dec_ok);
         end
         if (state == DONE && nxt == RELEASE) begin
            strap_ref <= '0;
            match <= '0;
            tries <= '0;
            err <= 1'b0;
         end
      end
   assign bus.lcd_id = id;
   assign bus.id_err = err;
   assign bus.id_valid = state == DONE;
   assign bus.busy = state != DONE;
   assign bus.lcd_rgb_oe = state == DONE && !err;
endmodule

// File: tb/tb_lcd_id_reader.sv
// tb_lcd_id_reader: directed strap scenarios with cycle-exact latency and decoded-ID checks.
module tb_lcd_id_reader;
`ifdef LCD_ID_SYNC_EN
   localparam int EX = 2;
`else
   localparam int EX = 0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int cyc;
   int checks = 0;
   int errors = 0;
   int c0;
   lcd_id_if bus ();
   lcd_id_reader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // Cycle index: posedges since rst_n deasserted.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else cyc <= cyc + 1;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic set_strap(input logic [2:0] s);
      logic [23:0] v;
      v = 24'ha5_5a_c3 ^ {8'(s), 8'(s), 8'(s)};
      v[7] = s[2];
      v[15] = s[1];
      v[23] = s[0];
      bus.lcd_rgb_in = v;
   endtask
   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask
   task automatic do_reset(input logic [2:0] s);
      #2 rst_n = 1'b0;
      set_strap(s);
      #1;
      check("rst_valid", 32'(bus.id_valid), 0);
      check("rst_id", 32'(bus.lcd_id), 0);
      check("rst_oe", 32'(bus.lcd_rgb_oe), 0);
      check("rst_busy", 32'(bus.busy), 1);
      check("rst_err", 32'(bus.id_err), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic wait_done(input string tag, input int exp);
      int n = 0;
      while (!bus.id_valid && n < 4000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, 32'(cyc), 32'(exp));
   endtask
   task automatic result(input string tag, input logic [15:0] id, input logic e);
      check({tag, "_id"}, 32'(bus.lcd_id), 32'(id));
      check({tag, "_err"}, 32'(bus.id_err), 32'(e));
      check({tag, "_oe"}, 32'(bus.lcd_rgb_oe), 32'(!e));
      check({tag, "_valid"}, 32'(bus.id_valid), 1);
      check({tag, "_busy"}, 32'(bus.busy), 0);
   endtask
   task automatic pulse_reread();
      @(negedge clk);
      bus.reread = 1'b1;
      c0 = cyc;
      @(negedge clk);
      bus.reread = 1'b0;
   endtask
   initial begin
      bus.reread = 1'b0;
      set_strap(3'b001);
      do_reset(3'b001);
      wait_done("lat_001", 1065 + EX);
      result("s001", 16'h7084, 1'b0);
      set_strap(3'b000);
      pulse_reread();
      check("rr_valid", 32'(bus.id_valid), 0);
      check("rr_oe", 32'(bus.lcd_rgb_oe), 0);
      check("rr_busy", 32'(bus.busy), 1);
      check("rr_hold_id", 32'(bus.lcd_id), 32'h7084);
      wait_cyc(c0 + 1 + 1030 + EX);
      bus.reread = 1'b1;
      @(negedge clk);
      bus.reread = 1'b0;
      check("rr_ignored_busy", 32'(bus.busy), 1);
      wait_done("lat_rr", c0 + 1 + 1065 + EX);
      result("s000", 16'h4342, 1'b0);
      set_strap(3'b101);
      pulse_reread();
      wait_cyc(c0 + 1 + 1030 + EX);
      #3 rst_n = 1'b0;
      #1;
      check("arst_id", 32'(bus.lcd_id), 0);
      check("arst_valid", 32'(bus.id_valid), 0);
      check("arst_busy", 32'(bus.busy), 1);
      check("arst_oe", 32'(bus.lcd_rgb_oe), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_done("lat_101", 1065 + EX);
      result("s101", 16'h1018, 1'b0);
      do_reset(3'b110);
      wait_done("lat_110", 1065 + EX);
      result("s110", 16'h0000, 1'b1);
      do_reset(3'b000);
      for (int k = 1; k <= 64; k++) begin
         wait_cyc(1008 + EX + 16 * (k - 1));
         set_strap(k[0] ? 3'b000 : 3'b100);
      end
      wait_done("lat_maxtry", 1000 + 64 * 16 + 1 + EX);
      result("maxtry", 16'h0000, 1'b1);
      do_reset(3'b010);
      wait_cyc(1008 + EX + 48);
      set_strap(3'b100);
      wait_cyc(1008 + EX + 64);
      set_strap(3'b010);
      wait_done("lat_glitch", 1000 + 8 * 16 + 1 + EX);
      result("s010", 16'h7016, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
